inst_fetch_req: RTL and testbench

Instruction-fetch request unit for the dual-issue core. It sits directly upstream of the SRAM-to-AXI bridge and drives its instruction port (`sram_ibus1` / `sram_obus1`). It owns the fetch PC, issues one SRAM-like read per instruction, and buffers the returned word until the IF stage accepts it. Redirects (branch or flush) cancel any in-flight fetch so that its late response is discarded.

---
 rtl/inst_fetch_req.sv | 132 +++++++++++++
 tb/tb_inst_fetch_req.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_req.sv
// Instruction-fetch request unit: owns the fetch PC, issues one SRAM-like read
// per instruction and buffers the returned word until IF takes it.
`timescale 1ns/1ps
module inst_fetch_req #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [71:0] sram_ibus,
  input  logic [33:0] sram_obus,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_o,
  output logic        adef_o
);

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } sram_rsp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adef;
  } ibuf_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2
  } fs_t;

  fs_t        fs;
  logic [31:0] pc_r;
  logic [31:0] req_pc_r;
  logic        cancel_r;
  ibuf_t       buf_r;
  sram_rsp_t   rsp;
  sram_req_t   req_s;
  logic        pc_mis;
  logic        req;

  assign rsp    = sram_obus;
  assign pc_mis = (pc_r[1:0] != 2'b00);

  // rst_n is active-high; dropping req on redirect guarantees addr_ok never
  // coincides with a redirect, so IDLE needs no redirect/addr_ok arbitration.
  assign req = !rst_n && (fs == IDLE) && !redirect_i && !pc_mis;

  always_comb begin
    req_s       = '0;
    req_s.req   = req;
    req_s.wr    = 1'b0;
    req_s.size  = 2'b10;
    req_s.wstrb = 4'b0000;
    req_s.addr  = pc_r;
    req_s.wdata = 32'h0;
  end

  assign sram_ibus = req_s;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fs       <= IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= '0;
      cancel_r <= 1'b0;
      buf_r    <= '0;
    end else begin
      case (fs)
        IDLE: begin
          if (redirect_i) begin
            pc_r <= redirect_pc_i;
          end else if (pc_mis) begin
            buf_r <= '{inst: 32'h0, pc: pc_r, adef: 1'b1};
            fs    <= HOLD;
          end else if (rsp.addr_ok) begin
            req_pc_r <= pc_r;
            pc_r     <= pc_r + 32'd4;
            fs       <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (rsp.data_ok) begin
            // a cancelled (or simultaneously redirected) response is absorbed here
            if (cancel_r || redirect_i) begin
              cancel_r <= 1'b0;
              fs       <= IDLE;
              if (redirect_i) pc_r <= redirect_pc_i;
            end else begin
              buf_r <= '{inst: rsp.rdata, pc: req_pc_r, adef: 1'b0};
              fs    <= HOLD;
            end
          end else if (redirect_i) begin
            pc_r     <= redirect_pc_i;
            cancel_r <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc_r  <= redirect_pc_i;
            buf_r <= '0;
            fs    <= IDLE;
          end else if (inst_ready_i) begin
            fs <= IDLE;
          end
        end
        default: fs <= IDLE;
      endcase
    end
  end

  assign inst_valid_o = (fs == HOLD);
  assign inst_pc_o    = buf_r.pc;
  assign inst_o       = buf_r.inst;
  assign adef_o       = buf_r.adef;

endmodule

// File: tb/tb_inst_fetch_req.sv
// Bench for inst_fetch_req: table of fetches plus hand-written redirect, cancel
// and reset sequences; responses are checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_inst_fetch_req;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [71:0] sram_ibus;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic [33:0] sram_obus;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_o;
  logic        adef_o;

  logic        req_w;
  logic [31:0] addr_w;

  assign sram_obus = {addr_ok, data_ok, rdata};
  assign req_w     = sram_ibus[71];
  assign addr_w    = sram_ibus[63:32];

  inst_fetch_req #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .sram_ibus     (sram_ibus),
    .sram_obus     (sram_obus),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_pc_o     (inst_pc_o),
    .inst_o        (inst_o),
    .adef_o        (adef_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  typedef struct {
    logic        adef;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] ea;
    int          ad;
    int          dd;
    logic [31:0] rd;
    int          rdy;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   errors = 0;
  int   checks = 0;
  logic outstanding = 1'b0;
  logic allow_stray = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Bus protocol watch: no stray data_ok, never two outstanding requests.
  always @(posedge clk) begin
    if (!rst_n) begin
      if (data_ok && !outstanding && !allow_stray) begin
        errors++;
        $display("FAIL protocol: data_ok with nothing outstanding at %0t", $time);
      end
      if (req_w && addr_ok && outstanding) begin
        errors++;
        $display("FAIL protocol: second request accepted at %0t", $time);
      end
      if (req_w && addr_ok) outstanding = 1'b1;
      else if (data_ok) outstanding = 1'b0;
    end else begin
      outstanding = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    #1;
    while (!req_w && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (!req_w) chk("wait_req_timeout", {31'b0, req_w}, 32'd1);
  endtask

  task automatic issue(input logic [31:0] ea, input int ad);
    wait_req();
    chk("req_addr", addr_w, ea);
    chk("req_const", {25'b0, sram_ibus[70:64]}, 32'h0000_0020);
    chk("req_wdata", sram_ibus[31:0], 32'h0);
    repeat (ad) begin
      tick();
      #1;
      chk("req_hold", {31'b0, req_w}, 32'd1);
    end
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
  endtask

  task automatic accept_check();
    exp_t e;
    chk("accept_valid", {31'b0, inst_valid_o}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("inst_pc", inst_pc_o, e.pc);
      chk("inst", inst_o, e.inst);
      chk("adef", {31'b0, adef_o}, {31'b0, e.adef});
    end
  endtask

  task automatic fetch_one(input logic [31:0] ea, input int ad, input int dd,
                           input logic [31:0] rd, input int rdy);
    issue(ea, ad);
    for (int i = 0; i < dd - 1; i++) begin
      #1;
      chk("wait_noreq", {31'b0, req_w}, 32'd0);
      chk("wait_novalid", {31'b0, inst_valid_o}, 32'd0);
      tick();
    end
    data_ok = 1'b1;
    rdata   = rd;
    sb.push_back('{pc: ea, inst: rd, adef: 1'b0});
    #1;
    chk("resp_novalid", {31'b0, inst_valid_o}, 32'd0);
    tick();
    data_ok = 1'b0;
    rdata   = $urandom;
    #1;
    chk("valid", {31'b0, inst_valid_o}, 32'd1);
    for (int i = 0; i < rdy; i++) begin
      chk("bp_noreq", {31'b0, req_w}, 32'd0);
      chk("bp_pc", inst_pc_o, ea);
      chk("bp_inst", inst_o, rd);
      chk("bp_valid", {31'b0, inst_valid_o}, 32'd1);
      tick();
      #1;
    end
    inst_ready_i = 1'b1;
    #1;
    accept_check();
    tick();
    inst_ready_i = 1'b0;
    #1;
    chk("post_accept_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("post_accept_req", {31'b0, req_w}, 32'd1);
    chk("next_addr", addr_w, ea + 32'd4);
  endtask

  task automatic redir(input logic [31:0] rpc);
    redirect_i    = 1'b1;
    redirect_pc_i = rpc;
    #1;
    chk("redir_noreq", {31'b0, req_w}, 32'd0);
    tick();
    redirect_i = 1'b0;
  endtask

  task automatic mis(input logic [31:0] rpc);
    redir(rpc);
    #1;
    chk("mis_noreq", {31'b0, req_w}, 32'd0);
    chk("mis_novalid", {31'b0, inst_valid_o}, 32'd0);
    sb.push_back('{pc: rpc, inst: 32'h0, adef: 1'b1});
    tick();
    #1;
    chk("mis_noreq2", {31'b0, req_w}, 32'd0);
    inst_ready_i = 1'b1;
    accept_check();
    tick();
    inst_ready_i = 1'b0;
    #1;
    chk("mis_post_valid", {31'b0, inst_valid_o}, 32'd0);
  endtask

  initial begin
    exp_t dropped;
    //         adef  redir rpc           ea            ad dd rd            rdy
    tbl[0] = '{1'b0, 1'b0, 32'h0,        32'h1c00_0000, 0, 3, 32'h0280_0400, 0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,        32'h1c00_0004, 2, 1, 32'h1234_5678, 5};
    tbl[2] = '{1'b1, 1'b1, 32'h1c00_0102, 32'h0,        0, 0, 32'h0,         0};
    tbl[3] = '{1'b0, 1'b1, 32'h1c00_0200, 32'h1c00_0200, 1, 2, 32'ha5a5_0001, 1};
    tbl[4] = '{1'b0, 1'b1, 32'hffff_fffc, 32'hffff_fffc, 0, 1, 32'hdead_beef, 0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        32'h0000_0000, 0, 2, 32'h0bad_f00d, 2};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_0006, 32'h0,        0, 0, 32'h0,         0};

    tick();
    tick();
    #1;
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_adef", {31'b0, adef_o}, 32'd0);
    chk("rst_req", {31'b0, req_w}, 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("first_req", {31'b0, req_w}, 32'd1);
    chk("first_addr", addr_w, RESET_PC);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].adef) begin
        mis(tbl[i].rpc);
      end else begin
        if (tbl[i].redir) redir(tbl[i].rpc);
        fetch_one(tbl[i].ea, tbl[i].ad, tbl[i].dd, tbl[i].rd, tbl[i].rdy);
      end
    end

    // Cancel in flight: redirect in WAIT_DATA, response two cycles later.
    redir(32'h1c00_0300);
    issue(32'h1c00_0300, 0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h1c00_0100;
    #1;
    chk("cancel_noreq", {31'b0, req_w}, 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("cancel_novalid1", {31'b0, inst_valid_o}, 32'd0);
    chk("cancel_noreq1", {31'b0, req_w}, 32'd0);
    tick();
    data_ok = 1'b1;
    rdata   = 32'h7777_7777;
    #1;
    chk("cancel_novalid2", {31'b0, inst_valid_o}, 32'd0);
    chk("cancel_noreq2", {31'b0, req_w}, 32'd0);
    tick();
    data_ok = 1'b0;
    #1;
    chk("cancel_novalid3", {31'b0, inst_valid_o}, 32'd0);
    chk("cancel_req", {31'b0, req_w}, 32'd1);
    chk("cancel_addr", addr_w, 32'h1c00_0100);
    fetch_one(32'h1c00_0100, 0, 1, 32'h0000_0100, 0);

    // Redirect in the same cycle as data_ok.
    redir(32'h1c00_0400);
    issue(32'h1c00_0400, 0);
    data_ok       = 1'b1;
    rdata         = 32'h4444_4444;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h1c00_0500;
    tick();
    data_ok    = 1'b0;
    redirect_i = 1'b0;
    #1;
    chk("simul_novalid", {31'b0, inst_valid_o}, 32'd0);
    chk("simul_req", {31'b0, req_w}, 32'd1);
    chk("simul_addr", addr_w, 32'h1c00_0500);
    fetch_one(32'h1c00_0500, 0, 2, 32'h5555_0500, 0);

    // Redirect in HOLD together with inst_ready_i: buffer discarded.
    redir(32'h1c00_0600);
    issue(32'h1c00_0600, 0);
    data_ok = 1'b1;
    rdata   = 32'h6666_0600;
    sb.push_back('{pc: 32'h1c00_0600, inst: 32'h6666_0600, adef: 1'b0});
    tick();
    data_ok = 1'b0;
    #1;
    chk("hold_valid", {31'b0, inst_valid_o}, 32'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h1c00_0700;
    inst_ready_i  = 1'b1;
    #1;
    chk("hold_redir_noreq", {31'b0, req_w}, 32'd0);
    dropped = sb.pop_front();
    tick();
    redirect_i   = 1'b0;
    inst_ready_i = 1'b0;
    #1;
    chk("hold_redir_novalid", {31'b0, inst_valid_o}, 32'd0);
    chk("hold_redir_req", {31'b0, req_w}, 32'd1);
    chk("hold_redir_addr", addr_w, 32'h1c00_0700);
    fetch_one(32'h1c00_0700, 0, 1, 32'h7070_0700, 0);

    // Async reset while a read is outstanding, then a stray response.
    issue(32'h1c00_0704, 0);
    rst_n = 1'b1;
    #1;
    chk("arst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("arst_req", {31'b0, req_w}, 32'd0);
    chk("arst_adef", {31'b0, adef_o}, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_rel_req", {31'b0, req_w}, 32'd1);
    chk("arst_rel_addr", addr_w, RESET_PC);
    allow_stray = 1'b1;
    data_ok     = 1'b1;
    rdata       = 32'hbad0_bad0;
    tick();
    data_ok = 1'b0;
    #1;
    allow_stray = 1'b0;
    chk("stray_novalid", {31'b0, inst_valid_o}, 32'd0);
    chk("stray_req", {31'b0, req_w}, 32'd1);
    chk("stray_addr", addr_w, RESET_PC);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
